ext_pipe: RTL and testbench



---
 rtl/ext_pkg.sv | 23 ++
 rtl/ext_pipe_if.sv | 32 +++
 rtl/ext_core.sv | 50 +++++
 rtl/ext_pipe.sv | 90 +++++++++
 tb/tb_ext_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_pkg.sv
// Shared types and helpers for the extension unit: operation encoding and
// the byte-offset width derived from the datapath width.
package ext_pkg;

  localparam int EXT_MODE_W = 3;

  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_ZERO  = 3'd0,
    EXT_SIGN  = 3'd1,
    EXT_UPPER = 3'd2,
    EXT_LB    = 3'd3,
    EXT_LBU   = 3'd4,
    EXT_LH    = 3'd5,
    EXT_LHU   = 3'd6,
    EXT_LW    = 3'd7
  } ext_mode_e;

  // Bits needed to address any byte lane of a data_w-bit word.
  function automatic int off_w(int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ext_pipe_if.sv
// Valid/ready request and result channels of the extension unit.
// master is the producer/consumer side, slave is the unit itself.
interface ext_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  localparam int OFF_W = ext_pkg::off_w(DATA_W);

  logic                 in_valid;
  logic                 in_ready;
  ext_pkg::ext_mode_e   in_mode;
  logic [DATA_W-1:0]    in_data;
  logic [OFF_W-1:0]     in_off;
  logic [TAG_W-1:0]     in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_err;

  modport master (
    output in_valid, in_mode, in_data, in_off, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_off, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

endinterface

// File: rtl/ext_core.sv
// Combinational extender: immediate zero/sign/upper extension and load-lane
// extraction with alignment checking. Shared with the decode stage.
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OFF_W  = off_w(DATA_W)
) (
  input  ext_mode_e         mode,
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] res,
  output logic              err
);

  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] lane;

  assign imm  = data[IMM_W-1:0];
  // Little-endian lanes: shifting by off bytes puts the addressed byte at [7:0].
  assign lane = data >> {off, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    res = '0;
    err = 1'b0;
    case (mode)
      EXT_ZERO:  res = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_SIGN:  res = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      EXT_UPPER: res = {imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_LB:    res = {{(DATA_W-8){lane[7]}}, lane[7:0]};
      EXT_LBU:   res = {{(DATA_W-8){1'b0}}, lane[7:0]};
      EXT_LH: begin
        err = off[0];
        res = {{(DATA_W-16){lane[15]}}, lane[15:0]};
      end
      EXT_LHU: begin
        err = off[0];
        res = {{(DATA_W-16){1'b0}}, lane[15:0]};
      end
      EXT_LW: begin
        err = |off;
        res = data;
      end
    endcase
    if (err) res = '0;
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered, flow-controlled extension stage: ext_core followed by a main
// output register M and a skid register S so in_ready is purely registered.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  ext_pipe_if.slave  bus
);

  localparam int OFF_W = off_w(DATA_W);

  logic [DATA_W-1:0] core_data;
  logic              core_err;

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data,  s_data;
  logic [TAG_W-1:0]  m_tag,   s_tag;
  logic              m_err,   s_err;

  logic accept;
  logic m_load;

  ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .OFF_W  (OFF_W)
  ) u_core (
    .mode (bus.in_mode),
    .data (bus.in_data),
    .off  (bus.in_off),
    .res  (core_data),
    .err  (core_err)
  );

  assign accept = bus.in_valid & ~s_valid;
  // M may be overwritten whenever it is empty or its result is leaving.
  assign m_load = ~m_valid | bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_tag   <= '0;
      m_err   <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_load) begin
      // S only ever holds the older beat, so it drains into M first.
      m_valid <= s_valid | accept;
      s_valid <= 1'b0;
      if (s_valid) begin
        m_data <= s_data;
        m_tag  <= s_tag;
        m_err  <= s_err;
      end else if (accept) begin
        m_data <= core_data;
        m_tag  <= bus.in_tag;
        m_err  <= core_err;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
    end
  end

  // NOTE: the skid payload has no reset; it is only ever read while s_valid is set.
  always_ff @(posedge clk) begin
    if (accept && !m_load) begin
      s_data <= core_data;
      s_tag  <= bus.in_tag;
      s_err  <= core_err;
    end
  end

  assign bus.in_ready  = ~s_valid;
  assign bus.out_valid = m_valid;
  assign bus.out_data  = m_data;
  assign bus.out_tag   = m_tag;
  assign bus.out_err   = m_err;

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed scenarios plus a randomized
// stream checked by a FIFO scoreboard with an arithmetic reference model.
module tb_ext_pipe;
  import ext_pkg::*;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int TAG_W  = 5;

  typedef struct packed {
    logic              err;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  exp_t sb_q[$];

  ext_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  ext_pipe #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: result of one beat from the extension rules, using plain arithmetic.
  function automatic exp_t ref_model(int mode, logic [31:0] d, int off, logic [TAG_W-1:0] tag);
    exp_t   e;
    longint v;
    e.tag  = tag;
    e.err  = 1'b0;
    e.data = '0;
    case (mode)
      0: e.data = d % 65536;
      1: begin
        v = d % 65536;
        if (v >= 32768) v = v - 65536;
        e.data = v[31:0];
      end
      2: e.data = (d % 65536) * 65536;
      3, 4: begin
        v = (d >> (8 * off)) % 256;
        if (mode == 3 && v >= 128) v = v - 256;
        e.data = v[31:0];
      end
      5, 6: begin
        if (off % 2 != 0) e.err = 1'b1;
        else begin
          v = (d >> (8 * off)) % 65536;
          if (mode == 5 && v >= 32768) v = v - 65536;
          e.data = v[31:0];
        end
      end
      default: begin
        if (off != 0) e.err = 1'b1;
        else e.data = d;
      end
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int mode, logic [31:0] d, int off, logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_mode  = ext_mode_e'(mode);
    bus.in_data  = d;
    bus.in_off   = 2'(off);
    bus.in_tag   = tag;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Occupancy view: M holds the queue head, S the second entry; capacity two.
  task automatic monitor();
    exp_t h;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
      end else begin
        checks++;
        if (bus.out_valid !== (sb_q.size() != 0)) begin
          errors++;
          $display("FAIL sb_out_valid: got %b, want %b", bus.out_valid, sb_q.size() != 0);
        end
        checks++;
        if (bus.in_ready !== (sb_q.size() < 2)) begin
          errors++;
          $display("FAIL sb_in_ready: got %b, want %b", bus.in_ready, sb_q.size() < 2);
        end
        if (bus.out_valid === 1'b1 && sb_q.size() != 0) begin
          h = sb_q[0];
          checks++;
          if ({bus.out_err, bus.out_tag, bus.out_data} !== h) begin
            errors++;
            $display("FAIL sb_result: got err=%b tag=%0d data=%h, want err=%b tag=%0d data=%h",
                     bus.out_err, bus.out_tag, bus.out_data, h.err, h.tag, h.data);
          end
        end
        if (flush) begin
          sb_q.delete();
        end else begin
          if (bus.out_valid && bus.out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
          if (bus.in_valid && bus.in_ready)
            sb_q.push_back(ref_model(int'(bus.in_mode), bus.in_data, int'(bus.in_off), bus.in_tag));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_tag !== '0 || bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h t=%0d e=%b, want all zero",
               bus.out_valid, bus.out_data, bus.out_tag, bus.out_err);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, want 1", bus.in_ready);
    end
  endtask

  task automatic test_imm();
    logic [31:0] want[3];
    want[0] = 32'h0000_8001;
    want[1] = 32'hFFFF_8001;
    want[2] = 32'h8001_0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(i, 32'h0000_8001, 3, 5'(10 + i));
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== want[i] || bus.out_tag !== 5'(10 + i) || bus.out_err !== 1'b0) begin
        errors++;
        $display("FAIL imm_mode%0d: got v=%b d=%h t=%0d e=%b, want v=1 d=%h t=%0d e=0",
                 i, bus.out_valid, bus.out_data, bus.out_tag, bus.out_err, want[i], 10 + i);
      end
    end
    step();
  endtask

  task automatic test_loads();
    int          mode[10];
    int          off[10];
    logic [31:0] want[10];
    logic        werr[10];
    mode = '{3, 3, 3, 4, 5, 6, 7, 5, 7, 5};
    off  = '{0, 1, 2, 3, 2, 0, 0, 1, 2, 0};
    want = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
             32'h0000_7F01, 32'h80FF_7F01, 32'h0, 32'h0, 32'h0000_7F01};
    werr = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(mode[i], 32'h80FF_7F01, off[i], 5'(i));
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== want[i] || bus.out_err !== werr[i] || bus.out_tag !== 5'(i)) begin
        errors++;
        $display("FAIL load_%0d_mode%0d_off%0d: got v=%b d=%h e=%b t=%0d, want v=1 d=%h e=%b t=%0d",
                 i, mode[i], off[i], bus.out_valid, bus.out_data, bus.out_err, bus.out_tag,
                 want[i], werr[i], i);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [TAG_W-1:0] got[$];
    logic             acc;
    bus.out_ready = 1'b0;
    send(7, 32'h1111_0001, 0, 5'd1);
    send(7, 32'h2222_0002, 0, 5'd2);
    bus.in_valid = 1'b1;
    bus.in_tag   = 5'd3;
    bus.in_data  = 32'h3333_0003;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got v=%b t=%0d rdy=%b, want v=1 t=1 rdy=0",
               bus.out_valid, bus.out_tag, bus.in_ready);
    end
    repeat (2) step();
    checks++;
    if (bus.out_tag !== 5'd1 || bus.out_data !== 32'h1111_0001) begin
      errors++;
      $display("FAIL bp_hold: got t=%0d d=%h, want t=1 d=11110001", bus.out_tag, bus.out_data);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_tag);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) begin
        if (bus.in_tag == 5'd4) bus.in_valid = 1'b0;
        else begin
          bus.in_tag  = bus.in_tag + 5'd1;
          bus.in_data = bus.in_data + 32'h1111_0001;
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d results, want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== 5'(i + 1)) begin
          errors++;
          $display("FAIL bp_order_%0d: got tag %0d, want %0d", i, got[i], i + 1);
        end
      end
    end
    step();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    send(1, 32'h0000_0007, 0, 5'd7);
    send(1, 32'h0000_0008, 0, 5'd8);
    bus.in_valid = 1'b1;
    bus.in_tag   = 5'd9;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    // Second case: room to accept, offered beat must still be dropped.
    send(1, 32'h0000_000A, 0, 5'd10);
    bus.in_valid = 1'b1;
    bus.in_tag   = 5'd11;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_drop_%0d: got v=%b t=%0d, want v=0", c, bus.out_valid, bus.out_tag);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(7, 32'hCAFE_0000 + 32'(i), 0, 5'(20 + i));
    bus.out_ready = 1'b0;
    send(7, 32'hDEAD_BEEF, 0, 5'd23);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: got v=%b, want 1", bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_tag !== '0) begin
      errors++;
      $display("FAIL arst_immediate: got v=%b d=%h t=%0d, want 0", bus.out_valid, bus.out_data, bus.out_tag);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_release: got rdy=%b v=%b, want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    send(1, 32'h1234_FFFE, 0, 5'd30);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_FFFE || bus.out_tag !== 5'd30) begin
      errors++;
      $display("FAIL arst_resume: got v=%b d=%h t=%0d, want v=1 d=fffffffe t=30",
               bus.out_valid, bus.out_data, bus.out_tag);
    end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_mode   = ext_mode_e'($urandom_range(0, 7));
      bus.in_data   = $urandom;
      bus.in_off    = 2'($urandom_range(0, 3));
      bus.in_tag    = 5'($urandom_range(0, 31));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 40) == 0);
      step();
    end
    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = EXT_ZERO;
    bus.in_data   = '0;
    bus.in_off    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    fork
      monitor();
      begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_imm();
    test_loads();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
